fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Write-side arbiter for `asyn_fifo`, living entirely in the `write_clk` domain. It shares the FIFO's single write port between `NUM_REQ` producers using a valid/ready handshake and round-robin bursts. It drives `winc`/`write_data` and never writes while `full` is high. The read side of the FIFO is untouched.

## Interface
- `DATA_W`, default 8: word width; matches the `asyn_fifo` data width.
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 4: maximum words per grant, 1..16.
- `CNT_W`, default 16: width of the write statistics counter.

Ports:
- `write_clk` in 1: the block's only clock.
- `wrst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a word.
- `req_data` in NUM_REQ*DATA_W: word of requester i at bits [i*DATA_W +: DATA_W].
- `req_ready` out NUM_REQ: requester i's word is accepted this cycle.
- `full` in 1: from `asyn_fifo`, in the `write_clk` domain.
- `winc` out 1: FIFO write enable.
- `write_data` out DATA_W: FIFO write data.
- `grant_id` out clog2(NUM_REQ): currently granted requester.
- `grant_active` out 1: state is BURST.
- `wr_count` out CNT_W: total words written; wraps modulo 2^CNT_W.

## Operation
- Decided: one clock; reset is asynchronous and active-low (`write_clk`, `wrst_n`).
- FSM states are IDLE and BURST.
- **IDLE:**
  - If any `req_valid` bit is set, select the first set bit scanning from `last+1` upward, modulo NUM_REQ.
  - Register it into `grant_id` and `last`, clear `burst_cnt`, and go to BURST.
  - With no `req_valid` bits set, stay in IDLE.
- **BURST** (g = `grant_id`):
  - `req_ready[g] = !full`; all other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[g] & req_ready[g]`.
  - `winc` equals that transfer term (combinational). `write_data` equals `req_data[g]` (combinational mux; value is don't-care when `winc` = 0).
  - On a transfer, `burst_cnt` increments and `wr_count` increments.
  - If `burst_cnt == MAX_BURST-1` on a transfer, go to IDLE.
  - If `req_valid[g] == 0`, go to IDLE (release); no transfer happens that cycle.
  - If `full == 1` while `req_valid[g] == 1`, stay in BURST, stall, and do not advance `burst_cnt`. There is no timeout.
- Requester rule: once `req_valid` is raised, valid and data stay stable until accepted. The arbiter does not check this.
- `winc` is never 1 while `full` is 1, including in the same cycle `full` rises.
- Reset values:
  - State IDLE.
  - `grant_id` = 0.
  - `last` = NUM_REQ-1, so requester 0 wins first.
  - `burst_cnt` = 0; `wr_count` = 0.
  - `req_ready` = 0; `winc` = 0; `grant_active` = 0.
- Reset asserted mid-burst aborts immediately (asynchronous). Any word not yet accepted is not written. The FIFO itself is reset separately via its own `wrst_n`.

## Timing
- Arbitration latency: `req_valid` is sampled high at edge N (IDLE), the grant is registered at N, and the earliest transfer is at edge N+1.
- Within a burst, words transfer back-to-back, one per cycle, while `!full`.
- Burst end: the last transfer at edge k puts the FSM in IDLE for cycle k→k+1. The next grant registers at k+1 and the next transfer is at k+2. This gives exactly one bubble cycle between bursts.
- Release on dropped valid costs one cycle (BURST→IDLE) plus one cycle of arbitration.
- `full` to `req_ready`/`winc` is purely combinational; there is zero-cycle stall response.
- Round-robin fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0, each for MAX_BURST words.

## Test plan
- **Single requester:** `req_valid[2]` held with data 0x10..0x17, `full` = 0. Required: two bursts of 4, `winc` high 4 cycles, 1 low, 4 high. FIFO receives 0x10..0x17 in order. `wr_count` = 8.
- **Round-robin with wrap:** all 4 valid continuously. Required: `grant_id` sequence 0,1,2,3,0. Each grant gives exactly 4 `winc` pulses with the matching requester's data.
- **Full stall:** force `full` = 1 for 3 cycles mid-burst after 2 words. Required: `winc` = 0 and `req_ready` = 0 for those 3 cycles, state stays BURST. After release, the remaining 2 words are written; total 4.
- **Early release:** requester 1 drops valid after 2 words while requester 3 is valid. Required: BURST→IDLE, then `grant_id` = 3 two cycles after requester 1's last transfer.
- **Reset mid-burst:** pulse `wrst_n` low between edges during a burst. Required: `winc`/`req_ready` go to 0 immediately, `wr_count` = 0. The first grant after reset goes to requester 0 if it is valid.
- **Counter wrap** (`CNT_W` = 4 build): 17 writes. Required: `wr_count` = 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for asyn_fifo: shares the single FIFO write port between
// NUM_REQ valid/ready producers using round-robin bursts of up to MAX_BURST words.

module fifo_wr_arb_lane #(
  parameter int DATA_W = 8,
  parameter int GID_W  = 2,
  parameter int LANE   = 0
) (
  input  logic              burst,
  input  logic [GID_W-1:0]  grant_id,
  input  logic              full,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              xfer,
  output logic [DATA_W-1:0] data_m
);
  logic sel;

  assign sel    = burst && (grant_id == GID_W'(LANE));
  // full gates ready with no register in between, so a rising full stalls this cycle
  assign ready  = sel && !full;
  assign xfer   = ready && valid;
  assign data_m = sel ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter  int DATA_W    = 8,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  parameter  int CNT_W     = 16,
  localparam int GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BC_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                      write_clk,
  input  logic                      wrst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full,
  output logic                      winc,
  output logic [DATA_W-1:0]         write_data,
  output logic [GID_W-1:0]          grant_id,
  output logic                      grant_active,
  output logic [CNT_W-1:0]          wr_count
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t                          state;
  logic [GID_W-1:0]                last;
  logic [BC_W-1:0]                 burst_cnt;
  logic [NUM_REQ-1:0]              xfer;
  logic [NUM_REQ-1:0][DATA_W-1:0]  lane_data;
  logic [GID_W-1:0]                pick;
  logic [GID_W-1:0]                cand;
  logic                            found;

  assign grant_active = (state == BURST);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arb_lane #(
      .DATA_W (DATA_W),
      .GID_W  (GID_W),
      .LANE   (i)
    ) u_lane (
      .burst    (grant_active),
      .grant_id (grant_id),
      .full     (full),
      .valid    (req_valid[i]),
      .data     (req_data[i*DATA_W +: DATA_W]),
      .ready    (req_ready[i]),
      .xfer     (xfer[i]),
      .data_m   (lane_data[i])
    );
  end

  assign winc = |xfer;

  // only the granted lane contributes non-zero data, so an OR tree is the mux
  always_comb begin
    write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) write_data = write_data | lane_data[i];
  end

  // round-robin pick: first valid scanning upward from last+1, wrapping
  always_comb begin
    pick  = last;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GID_W'((int'(last) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge write_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      last      <= GID_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= pick;
            last      <= pick;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!req_valid[grant_id]) begin
            state <= IDLE;
          end else if (winc) begin
            wr_count  <= wr_count + CNT_W'(1);
            burst_cnt <= burst_cnt + BC_W'(1);
            if (burst_cnt == BC_W'(MAX_BURST - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
